// File: rtl/sto_write_buffer.sv
// -----------------------------------------------------------------------------
// sto_write_buffer
//
// Write side of the data-memory interface. STO store requests handed over from
// the MEM/WB pipeline register are queued in a small circular FIFO and drained
// to the data RAM one at a time over a we/ack handshake. Loads can look up the
// queue combinationally so they observe stores that have not reached RAM yet.
//
// Parameters
//   DEPTH  number of queued stores (power of two, >= 2)
//   AW     address width
//   DW     data width
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_mem_write store request valid
//   in_imm       store address
//   in_mem_data  store data
//   full         queue holds DEPTH entries; upstream must stall
//   empty        queue holds no entries
//   count        current occupancy
//   overflow     sticky: a store arrived while full and was dropped
//   ram_we       write strobe to the data RAM
//   ram_addr     write address (head entry), zero while ram_we is low
//   ram_wdata    write data (head entry), zero while ram_we is low
//   ram_ack      RAM accepted the write this cycle
//   lookup_addr  load address to check against queued stores
//   lookup_hit   a queued store matches lookup_addr
//   lookup_data  data of the youngest matching store, zero on miss
// -----------------------------------------------------------------------------
module sto_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_mem_write,
    input  logic [AW-1:0]               in_imm,
    input  logic [DW-1:0]               in_mem_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        ram_we,
    output logic [AW-1:0]               ram_addr,
    output logic [DW-1:0]               ram_wdata,
    input  logic                        ram_ack,
    input  logic [AW-1:0]               lookup_addr,
    output logic                        lookup_hit,
    output logic [DW-1:0]               lookup_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state;

    // Queue storage holds only data; it carries no reset because validity is
    // tracked entirely by head/count.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          push_ok;
    logic          pop;
    logic [CW-1:0] count_next;

    // Occupancy flags come straight from the registered count.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push while full is dropped; a pop only happens on an acknowledged
    // strobe, so ram_ack while ram_we is low has no effect.
    assign push_ok    = in_mem_write & ~full;
    assign pop        = ram_we & ram_ack;
    assign count_next = count + CW'(push_ok) - CW'(pop);

    // Head entry is presented only while strobing so idle outputs read zero.
    // head cannot move while ram_we waits for ack, and a push never lands on
    // the head slot while it is occupied, so these stay stable during a stall.
    assign ram_addr  = ram_we ? addr_mem[head] : '0;
    assign ram_wdata = ram_we ? data_mem[head] : '0;

    // -------------------------------------------------------------------------
    // Queue storage write
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[tail] <= in_imm;
            data_mem[tail] <= in_mem_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy, overflow flag and drain FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ram_we   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count_next;

            if (in_mem_write && full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // Strobe rises the cycle after count is seen nonzero.
                    if (count != '0) begin
                        state  <= WRITE;
                        ram_we <= 1'b1;
                    end
                end
                WRITE: begin
                    // Keep strobing back-to-back while anything remains,
                    // including a store pushed in the same ack cycle.
                    if (ram_ack && (count_next == '0)) begin
                        state  <= IDLE;
                        ram_we <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Store-to-load bypass lookup
    // -------------------------------------------------------------------------
    // Walk from oldest (head) to youngest; later matches overwrite earlier
    // ones so the youngest matching store wins.
    logic [PW-1:0] lk_idx;

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = head + PW'(k);
            if ((CW'(k) < count) && (addr_mem[lk_idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_sto_write_buffer.sv
module tb_sto_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_mem_write;
    logic [AW-1:0] in_imm;
    logic [DW-1:0] in_mem_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;

    int checks = 0;
    int errors = 0;

    // Expected RAM writes in order: {addr, data}
    logic [AW+DW-1:0] exp_q[$];

    sto_write_buffer #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_mem_write(in_mem_write),
        .in_imm      (in_imm),
        .in_mem_data (in_mem_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_ack     (ram_ack),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one store for one edge; acc says whether it must reach RAM.
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit acc);
        in_mem_write = 1'b1;
        in_imm       = a;
        in_mem_data  = d;
        if (acc) exp_q.push_back({a, d});
        tick();
        in_mem_write = 1'b0;
    endtask

    // Monitor: every accepted RAM write is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ram_we && ram_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h_%0h required=none", ram_addr, ram_wdata);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
                chk("wr_data", 32'(ram_wdata), 32'(e[DW-1:0]));
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    logic [5:0] we_hist;

    initial begin
        rst          = 1'b1;
        in_mem_write = 1'b0;
        in_imm       = '0;
        in_mem_data  = '0;
        ram_ack      = 1'b0;
        lookup_addr  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count",    32'(count), 0);
        chk("rst_empty",    32'(empty), 1);
        chk("rst_full",     32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_we",       32'(ram_we), 0);
        chk("rst_addr",     32'(ram_addr), 0);
        chk("rst_hit",      32'(lookup_hit), 0);
        chk("rst_ldata",    32'(lookup_data), 0);

        // Single store: 2-cycle push-to-strobe latency
        push(8'h10, 8'hAB, 1'b1);
        chk("s1_count", 32'(count), 1);
        chk("s1_we_lo", 32'(ram_we), 0);
        lookup_addr = 8'h10;
        #1;
        chk("s1_hit",   32'(lookup_hit), 1);
        chk("s1_ldata", 32'(lookup_data), 32'hAB);
        tick();
        chk("s1_we_hi", 32'(ram_we), 1);
        chk("s1_addr",  32'(ram_addr), 32'h10);
        chk("s1_wdata", 32'(ram_wdata), 32'hAB);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        chk("s1_count0", 32'(count), 0);
        chk("s1_empty",  32'(empty), 1);
        chk("s1_we_off", 32'(ram_we), 0);
        chk("s1_hit0",   32'(lookup_hit), 0);

        // Back-to-back drain with ack tied high
        ram_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_mem_write = 1'b1;
                in_imm       = 8'(i + 1);
                in_mem_data  = 8'(8'hA1 + i);
                exp_q.push_back({8'(i + 1), 8'(8'hA1 + i)});
            end else begin
                in_mem_write = 1'b0;
            end
            tick();
            we_hist[i] = ram_we;
        end
        ram_ack = 1'b0;
        chk("b2b_we_pattern", 32'(we_hist), 32'b011110);
        chk("b2b_count", 32'(count), 0);
        chk("b2b_empty", 32'(empty), 1);

        // Overflow: fill with no ack, fifth store dropped
        push(8'h31, 8'hC1, 1'b1);
        push(8'h32, 8'hC2, 1'b1);
        push(8'h33, 8'hC3, 1'b1);
        chk("ov_full_3", 32'(full), 0);
        push(8'h34, 8'hC4, 1'b1);
        chk("ov_full",   32'(full), 1);
        chk("ov_count4", 32'(count), 4);
        chk("ov_flag0",  32'(overflow), 0);
        push(8'h35, 8'hC5, 1'b0);
        chk("ov_flag1",  32'(overflow), 1);
        chk("ov_count_hold", 32'(count), 4);
        // Push in the popping ack cycle while full is also dropped
        ram_ack = 1'b1;
        push(8'h36, 8'hC6, 1'b0);
        chk("ov_count3",  32'(count), 3);
        chk("ov_notfull", 32'(full), 0);
        tick();
        tick();
        tick();
        ram_ack = 1'b0;
        chk("ov_drained", 32'(count), 0);
        chk("ov_we_off",  32'(ram_we), 0);
        chk("ov_sticky",  32'(overflow), 1);
        chk("ov_q_empty", 32'(exp_q.size()), 0);

        // Ack stall: outputs stable while waiting
        push(8'h40, 8'h55, 1'b1);
        push(8'h41, 8'h66, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_we",    32'(ram_we), 1);
            chk("stall_addr",  32'(ram_addr), 32'h40);
            chk("stall_wdata", 32'(ram_wdata), 32'h55);
            tick();
        end
        chk("stall_count", 32'(count), 2);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        chk("stall_pop1",  32'(count), 1);
        chk("stall_next",  32'(ram_addr), 32'h41);
        chk("stall_nextd", 32'(ram_wdata), 32'h66);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        chk("stall_done", 32'(count), 0);

        // Bypass: youngest match wins
        push(8'h20, 8'h11, 1'b1);
        push(8'h20, 8'h22, 1'b1);
        lookup_addr = 8'h20;
        #1;
        chk("byp_hit",   32'(lookup_hit), 1);
        chk("byp_data",  32'(lookup_data), 32'h22);
        lookup_addr = 8'h21;
        #1;
        chk("byp_miss",  32'(lookup_hit), 0);
        chk("byp_mdata", 32'(lookup_data), 0);
        lookup_addr = 8'h20;
        ram_ack = 1'b1;
        tick();
        chk("byp_hit_after1",  32'(lookup_hit), 1);
        chk("byp_data_after1", 32'(lookup_data), 32'h22);
        tick();
        ram_ack = 1'b0;
        chk("byp_hit_drained", 32'(lookup_hit), 0);
        chk("byp_data_drained", 32'(lookup_data), 0);

        // Reset mid-operation (overflow still set from earlier)
        push(8'h50, 8'h70, 1'b1);
        push(8'h51, 8'h71, 1'b1);
        push(8'h52, 8'h72, 1'b1);
        chk("mr_count", 32'(count), 3);
        chk("mr_we",    32'(ram_we), 1);
        chk("mr_ovf",   32'(overflow), 1);
        lookup_addr = 8'h50;
        rst     = 1'b1;
        ram_ack = 1'b1;
        exp_q.delete();
        tick();
        chk("mr_we_off",  32'(ram_we), 0);
        chk("mr_count0",  32'(count), 0);
        chk("mr_empty",   32'(empty), 1);
        chk("mr_ovf0",    32'(overflow), 0);
        chk("mr_hit0",    32'(lookup_hit), 0);
        rst     = 1'b0;
        ram_ack = 1'b0;
        tick();
        chk("mr_we_idle", 32'(ram_we), 0);
        chk("mr_final_q", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sto_write_buffer.md
# sto_write_buffer

Data-memory write side of the pipeline: accepts STO store requests (address + data) handed from MEM to WB, queues them in a small FIFO, and drains them to the data RAM over a we/ack handshake. It is the write end of the data-memory interface, complementing the MEM-stage read path. It also provides a store-to-load bypass lookup so loads see stores that are still queued.

## Interface
- DEPTH, 4, number of queued stores; power of two, >= 2
- AW, 8, address width
- DW, 8, data width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_mem_write  in  1  store request valid (from MEM/WB pipeline register)
- in_imm  in  AW  store address
- in_mem_data  in  DW  store data
- full  out  1  queue holds DEPTH entries; upstream must stall
- empty  out  1  queue holds 0 entries
- count  out  log2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a store arrived while full and was dropped
- ram_we  out  1  write strobe to data RAM
- ram_addr  out  AW  write address (head entry)
- ram_wdata  out  DW  write data (head entry)
- ram_ack  in  1  RAM accepted the write this cycle
- lookup_addr  in  AW  load address to check
- lookup_hit  out  1  a queued store matches lookup_addr
- lookup_data  out  DW  data of youngest matching queued store

## Operation
- Storage: DEPTH entries {addr, data}, head/tail pointers wrapping mod DEPTH, count register.
- Push: in_mem_write=1 and full=0 -> entry written at tail, tail++. in_mem_write=1 and full=1 -> request dropped, overflow set (cleared only by rst).
- Pop: ram_we=1 and ram_ack=1 -> head++.
- Simultaneous push and pop (not full): both happen, count unchanged.
- full = (count==DEPTH), empty = (count==0); both derived from the registered count.
- FSM, two states:
  - IDLE: ram_we=0. If count!=0 -> WRITE.
  - WRITE: ram_we=1, ram_addr/ram_wdata = head entry. Stay until ram_ack. On ack: if count after pop !=0 stay WRITE (next head presented next cycle), else -> IDLE.
- ram_ack while ram_we=0 is ignored.
- ram_addr/ram_wdata stable for the whole time ram_we is held waiting for ack.
- Lookup (combinational): compare lookup_addr against all valid entries; lookup_hit=1 on any match; lookup_data = data of the youngest (closest to tail) match; lookup_data=0 when no hit. A push in the same cycle is not visible until the next cycle. The head entry stays visible until the cycle after its ack.
- Reset: all outputs zero except empty=1; state IDLE; pointers and count 0; queued stores discarded. Reset mid-write drops ram_we in the cycle after the reset edge, regardless of ack.

## Timing
- Push sampled at edge E -> count/lookup updated after E.
- First ram_we high one cycle after count becomes nonzero (push at E -> FSM to WRITE at E+1 -> ram_we high in the cycle after E+1). Push-to-strobe latency is 2 cycles.
- With ram_ack tied high, throughput is one write per cycle after the first strobe.
- The full→not-full transition occurs the cycle after the popping ack. A push in the ack cycle while full is dropped.

## Test plan
- Single store: push (0x10, 0xAB) -> count=1; ram_we high 2 cycles later with addr 0x10/data 0xAB; ack -> count=0, empty=1, FSM IDLE next cycle.
- Back-to-back drain: push 4 stores (0x01..0x04, data 0xA1..0xA4) with ram_ack=1 -> 4 consecutive ram_we cycles in FIFO order; full=1 asserted after 4th push if no pop yet.
- Overflow: ram_ack=0, push 5 stores -> full=1 after 4, 5th dropped, overflow=1 sticky; then ack 4 times -> exactly 4 writes, the 5th address is never written.
- Ack stall: hold ram_ack=0 for 3 cycles -> ram_we, ram_addr, and ram_wdata stay constant; ack pops exactly one entry.
- Bypass: queue (0x20,0x11) then (0x20,0x22), lookup 0x20 -> hit=1, data=0x22; lookup 0x21 -> hit=0, data=0.
- Reset mid-operation: 3 queued, ram_we high, assert rst -> next cycle ram_we=0, count=0, empty=1, overflow=0, lookup_hit=0.
